// File: rtl/piso_bit_serializer_if.sv
// Handshake and serial-stream bundle for piso_bit_serializer.
// master: upstream word source plus the downstream hold/observer side.
// slave : the serializer itself.
interface piso_bit_serializer_if #(
    parameter int WIDTH = 8
) ();

    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic             hold;
    logic             sout;
    logic             sout_valid;
    logic             frame_done;

    modport master (
        output din,
        output din_valid,
        output hold,
        input  din_ready,
        input  sout,
        input  sout_valid,
        input  frame_done
    );

    modport slave (
        input  din,
        input  din_valid,
        input  hold,
        output din_ready,
        output sout,
        output sout_valid,
        output frame_done
    );

endinterface

// File: rtl/piso_bit_serializer.sv
// Parallel-in / serial-out bit serializer feeding a serial sequence detector.
// Words of WIDTH bits are accepted over din_valid/din_ready and shifted out
// MSB first, one bit per clock, with gapless back-to-back frames and a
// downstream hold that freezes the presented bit.
//
// Optional feature: define SER_PARITY_EN to append an even-parity bit after
// the data bits (frame length WIDTH+1 instead of WIDTH).
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | no frame in flight, sout=0, ready for a new word
// SHIFT  | presenting frame bit cnt_q on sout, sout_valid=1
module piso_bit_serializer #(
    parameter int WIDTH = 8
) (
    input  logic                  clck,
    input  logic                  rst,
    piso_bit_serializer_if.slave  bus
);

`ifdef SER_PARITY_EN
    localparam int FL = WIDTH + 1;
`else
    localparam int FL = WIDTH;
`endif
    localparam int            CW       = $clog2(FL + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(FL - 1);
`ifdef SER_PARITY_EN
    // Counter value while the final data bit is on sout; parity follows it.
    localparam logic [CW-1:0] CNT_DATA_LAST = CW'(WIDTH - 1);
`endif

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]    cnt_q,   cnt_d;
    logic             sout_q,  sout_d;
`ifdef SER_PARITY_EN
    logic             parity_q, parity_d;
`endif

    logic last_bit;
    logic consume;
    logic ready;
    logic accept;

    // Handshake decode: only registers and hold feed ready/frame_done,
    // din_valid only qualifies the accept.
    always_comb begin
        last_bit = (state_q == ST_SHIFT) && (cnt_q == CNT_LAST);
        consume  = (state_q == ST_SHIFT) && !bus.hold;
        ready    = (state_q == ST_IDLE) || (last_bit && !bus.hold);
        accept   = bus.din_valid && ready;
    end

    // Next-state and datapath update for the frame sequencer.
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        cnt_d    = cnt_q;
        sout_d   = sout_q;
`ifdef SER_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d  = ST_SHIFT;
                    shift_d  = bus.din;
                    cnt_d    = '0;
                    sout_d   = bus.din[WIDTH-1];
`ifdef SER_PARITY_EN
                    parity_d = ^bus.din;
`endif
                end
            end
            ST_SHIFT: begin
                if (consume) begin
                    if (last_bit) begin
                        if (bus.din_valid) begin
                            // Back-to-back: next word's MSB follows with no gap.
                            state_d  = ST_SHIFT;
                            shift_d  = bus.din;
                            cnt_d    = '0;
                            sout_d   = bus.din[WIDTH-1];
`ifdef SER_PARITY_EN
                            parity_d = ^bus.din;
`endif
                        end else begin
                            state_d = ST_IDLE;
                            cnt_d   = '0;
                            sout_d  = 1'b0;
                        end
                    end else begin
                        cnt_d   = cnt_q + CW'(1);
                        // Rotate so the word recirculates; the bit after the
                        // current MSB becomes the next presented bit.
                        shift_d = {shift_q[WIDTH-2:0], shift_q[WIDTH-1]};
`ifdef SER_PARITY_EN
                        if (cnt_q == CNT_DATA_LAST) begin
                            sout_d = parity_q;
                        end else begin
                            sout_d = shift_q[WIDTH-2];
                        end
`else
                        sout_d  = shift_q[WIDTH-2];
`endif
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                sout_d  = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset; reset discards
    // any partial frame.
    always_ff @(posedge clck) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            shift_q  <= '0;
            cnt_q    <= '0;
            sout_q   <= 1'b0;
`ifdef SER_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            cnt_q    <= cnt_d;
            sout_q   <= sout_d;
`ifdef SER_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    // Output drive: sout/sout_valid straight from flops.
    always_comb begin
        bus.sout       = sout_q;
        bus.sout_valid = (state_q == ST_SHIFT);
        bus.din_ready  = ready;
        bus.frame_done = last_bit && !bus.hold;
    end

endmodule

// File: tb/tb_piso_bit_serializer.sv
// Self-checking bench for piso_bit_serializer. The reference model is a
// queue of pending frame bits: the head is the bit on sout, a consume pops
// it, and an accept appends the whole new frame.
module tb_piso_bit_serializer;

    localparam int WIDTH = 8;
`ifdef SER_PARITY_EN
    localparam int FL  = WIDTH + 1;
    localparam bit PAR = 1'b1;
`else
    localparam int FL  = WIDTH;
    localparam bit PAR = 1'b0;
`endif

    logic clck = 1'b0;
    logic rst  = 1'b1;

    piso_bit_serializer_if #(.WIDTH(WIDTH)) bus ();

    piso_bit_serializer #(.WIDTH(WIDTH)) dut (
        .clck (clck),
        .rst  (rst),
        .bus  (bus)
    );

    always #5 clck = ~clck;

    int   checks   = 0;
    int   failures = 0;
    bit   model_q[$];
    logic exp_valid, exp_sout, exp_ready, exp_done;
    logic [3:0]  got, exp;
    logic [31:0] col;
    int   nvalid, ndone;

    function automatic logic [31:0] frame_of(input logic [WIDTH-1:0] w);
        logic [31:0] f;
        f = {{(32-WIDTH){1'b0}}, w};
        if (PAR) f = (f << 1) | {31'b0, ^w};
        return f;
    endfunction

    // Drive inputs mid-cycle and compute the model's view of the outputs.
    task automatic apply(input logic r, input logic v, input logic [WIDTH-1:0] d, input logic h);
        @(negedge clck);
        rst           = r;
        bus.din_valid = v;
        bus.din       = d;
        bus.hold      = h;
        #1;
        exp_valid = (model_q.size() != 0);
        exp_sout  = exp_valid ? model_q[0] : 1'b0;
        exp_done  = (model_q.size() == 1) && !h;
        exp_ready = (model_q.size() == 0) || exp_done;
        got = {bus.sout_valid, bus.sout, bus.din_ready, bus.frame_done};
        exp = {exp_valid, exp_sout, exp_ready, exp_done};
        if (bus.sout_valid === 1'b1 && h === 1'b0) col = {col[30:0], bus.sout};
        if (bus.sout_valid === 1'b1) nvalid++;
        if (bus.frame_done === 1'b1) ndone++;
    endtask

    // Advance the reference model on the rising edge.
    task automatic tick();
        logic acc;
        @(posedge clck);
        if (rst) begin
            model_q.delete();
        end else begin
            acc = bus.din_valid && exp_ready;
            if (model_q.size() != 0 && !bus.hold) void'(model_q.pop_front());
            if (acc) begin
                for (int i = WIDTH - 1; i >= 0; i--) model_q.push_back(bus.din[i]);
                if (PAR) model_q.push_back(^bus.din);
            end
        end
    endtask

    task automatic clear_stats();
        col = '0; nvalid = 0; ndone = 0;
    endtask

    task automatic test_reset();
        apply(1'b1, 1'b0, '0, 1'b0); tick();
        apply(1'b1, 1'b1, 8'hFF, 1'b1); tick();
        apply(1'b0, 1'b0, '0, 1'b1);
        checks++;
        if (got !== 4'b0010) begin
            failures++;
            $display("FAIL reset_state got=%b required=%b", got, 4'b0010);
        end
        tick();
    endtask

    task automatic test_single();
        clear_stats();
        for (int c = 0; c <= FL + 2; c++) begin
            apply(1'b0, c == 0, (c == 0) ? 8'h96 : WIDTH'($urandom), 1'b0);
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL single c=%0d got=%b required=%b", c, got, exp);
            end
            tick();
        end
        checks++;
        if (col !== frame_of(8'h96) || nvalid != FL || ndone != 1) begin
            failures++;
            $display("FAIL single_frame bits=%h nvalid=%0d ndone=%0d required bits=%h nvalid=%0d ndone=1",
                     col, nvalid, ndone, frame_of(8'h96), FL);
        end
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] words [2];
        int sent;
        int nready;
        words[0] = 8'h96; words[1] = 8'h69;
        sent = 0; nready = 0;
        clear_stats();
        for (int c = 0; c <= 2 * FL + 2; c++) begin
            apply(1'b0, sent < 2, (sent < 2) ? words[sent] : '0, 1'b0);
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL back_to_back c=%0d got=%b required=%b", c, got, exp);
            end
            if (c < 2 * FL && bus.din_ready === 1'b1) nready++;
            if (sent < 2 && exp_ready) sent++;
            tick();
        end
        checks++;
        if (col !== ((frame_of(8'h96) << FL) | frame_of(8'h69)) || nvalid != 2 * FL
            || ndone != 2 || nready != 2) begin
            failures++;
            $display("FAIL back_to_back_stream bits=%h nvalid=%0d ndone=%0d nready=%0d required bits=%h nvalid=%0d ndone=2 nready=2",
                     col, nvalid, ndone, nready, (frame_of(8'h96) << FL) | frame_of(8'h69), 2 * FL);
        end
    endtask

    task automatic test_hold();
        int nheld_one;
        nheld_one = 0;
        clear_stats();
        for (int c = 0; c <= FL + 5; c++) begin
            apply(1'b0, c == 0, 8'h96, (c >= 4) && (c < 7));
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL hold c=%0d got=%b required=%b", c, got, exp);
            end
            if (c >= 4 && c <= 7 && bus.sout === 1'b1) nheld_one++;
            tick();
        end
        checks++;
        if (col !== frame_of(8'h96) || nvalid != FL + 3 || ndone != 1 || nheld_one != 4) begin
            failures++;
            $display("FAIL hold_frame bits=%h nvalid=%0d ndone=%0d held=%0d required bits=%h nvalid=%0d ndone=1 held=4",
                     col, nvalid, ndone, nheld_one, frame_of(8'h96), FL + 3);
        end
    endtask

    task automatic test_reset_mid();
        clear_stats();
        for (int c = 0; c <= 5; c++) begin
            apply(c == 4, c == 0, 8'h96, 1'b0);
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL reset_mid c=%0d got=%b required=%b", c, got, exp);
            end
            if (c == 5) begin
                checks++;
                if (got !== 4'b0010 || ndone != 0) begin
                    failures++;
                    $display("FAIL reset_mid_idle got=%b ndone=%0d required=0010 ndone=0", got, ndone);
                end
            end
            tick();
        end
        clear_stats();
        for (int c = 0; c <= FL + 1; c++) begin
            apply(1'b0, c == 0, 8'hA5, 1'b0);
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL reset_mid_next c=%0d got=%b required=%b", c, got, exp);
            end
            tick();
        end
        checks++;
        if (col !== frame_of(8'hA5) || ndone != 1) begin
            failures++;
            $display("FAIL reset_mid_a5 bits=%h ndone=%0d required bits=%h ndone=1", col, ndone, frame_of(8'hA5));
        end
    endtask

    task automatic test_ignore_mid();
        clear_stats();
        for (int c = 0; c <= FL + 2; c++) begin
            apply(1'b0, (c == 0) || (c == 3), (c == 0) ? 8'h96 : 8'hFF, 1'b0);
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL ignore_mid c=%0d got=%b required=%b", c, got, exp);
            end
            tick();
        end
        checks++;
        if (col !== frame_of(8'h96) || nvalid != FL || ndone != 1) begin
            failures++;
            $display("FAIL ignore_mid_frame bits=%h nvalid=%0d ndone=%0d required bits=%h", col, nvalid, ndone, frame_of(8'h96));
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            apply($urandom_range(0, 59) == 0, $urandom_range(0, 2) != 0,
                  WIDTH'($urandom), $urandom_range(0, 3) == 0);
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL random c=%0d got=%b required=%b", c, got, exp);
            end
            tick();
        end
    endtask

    initial begin
        bus.din       = '0;
        bus.din_valid = 1'b0;
        bus.hold      = 1'b0;
        clear_stats();
        test_reset();
        test_single();
        test_back_to_back();
        test_hold();
        test_reset_mid();
        test_ignore_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/piso_bit_serializer.md
# piso_bit_serializer

Parallel-in/serial-out stage that sits directly upstream of the serial sequence detectors (e.g. the 1001 Mealy detector). It accepts WIDTH-bit words over a valid/ready handshake and drives them onto a single-bit stream, one bit per clock, for the detector's `in` port. It supports back-to-back words with no gap bits, a downstream hold, and an optional appended parity bit.

## Interface
- `WIDTH`, 8: data bits per word, ≥2.
- `clck`  in  1  system clock, rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `din`  in  WIDTH  parallel word to serialize.
- `din_valid`  in  1  `din` is valid this cycle.
- `din_ready`  out  1  the serializer can accept `din` this cycle (combinational).
- `hold`  in  1  downstream stall: freeze the presented bit.
- `sout`  out  1  serial bit stream; connect to the detector `in`.
- `sout_valid`  out  1  `sout` carries a frame bit.
- `frame_done`  out  1  one-cycle pulse in the cycle the last frame bit is consumed.

## Operation
- Frame length is FL = WIDTH, or WIDTH+1 with the `SER_PARITY_EN` macro. Bits go out MSB first (`din[WIDTH-1]` first).
- States:
  - IDLE: `sout_valid=0`, `din_ready=1`.
  - SHIFT: `sout_valid=1`.
- Internal registers: WIDTH-bit shift register, bit counter (0..FL-1, width $clog2(FL+1)), and parity register when enabled.
- Accept means a rising edge with `din_valid && din_ready`. On accept, the shift register loads `din`, the counter clears to 0, `sout` takes `din[WIDTH-1]`, and the state goes to SHIFT.
- Consume means a rising edge in SHIFT with `hold=0`. On consume, the next bit is presented and the counter increments.
  - Counter at FL-1 with `din_valid=1`: the next word loads (back-to-back).
  - Counter at FL-1 with `din_valid=0`: the state goes to IDLE and `sout` goes to 0.
- `din_ready` = IDLE, or (SHIFT && counter==FL-1 && !hold). It is never high mid-frame.
- `hold=1` in SHIFT freezes `sout`, the counter and the shift register. `sout_valid` stays 1, and the detector side gates on `hold`. `hold` is ignored in IDLE.
- `frame_done` = SHIFT && counter==FL-1 && !hold.
- `din_valid` without `din_ready` is ignored, and `din` is not captured.
- Reset, including mid-frame: state IDLE, `sout=0`, `sout_valid=0`, counter 0, shift register 0, parity 0, `frame_done=0`, `din_ready=1` in the first cycle after reset. A partial frame is discarded with no `frame_done`. Reset wins over every other input.

## Timing
- Latency: the first bit is on `sout` in the cycle after the accepting edge. An unheld frame occupies exactly FL consecutive cycles.
- Throughput: one bit per clock. Back-to-back words produce a continuous stream with `sout_valid` never dropping.
- `sout` and `sout_valid` are registered outputs. `din_ready` and `frame_done` are combinational from registers and `hold` only, with no path from `din_valid`.
- Simultaneous last-bit consume and new accept: the new word's first bit appears in the very next cycle.
- Simultaneous `hold` and last bit: no accept, no `frame_done`, and the bit is re-presented.

## Configuration
- `SER_PARITY_EN` defined:
  - FL = WIDTH+1.
  - The parity register is captured on accept as ^`din` (even parity).
  - After the last data bit, the parity bit is presented as bit FL-1.
  - `frame_done` and the `din_ready` window move to the parity cycle.
- Not defined: FL = WIDTH, with no parity logic or register.

## Test plan
- Reset, then `din=8'h96` with `din_valid=1` for one cycle → `sout` = 1,0,0,1,0,1,1,0 on cycles 1–8, `sout_valid`=1 for exactly 8 cycles, `frame_done` in cycle 8, back to IDLE with `sout=0` in cycle 9.
- 8'h96 then 8'h69 with `din_valid` held high → 16 contiguous valid bits 1001011001101001, `din_ready` high only in cycles 0, 8 and 16+, two `frame_done` pulses.
- `hold=1` for 3 cycles while bit 3 is presented during 8'h96 → `sout=1` held 4 cycles total, frame ends at cycle 11, still exactly one `frame_done`.
- `rst` asserted in cycle 4 of a frame → next cycle `sout=0`, `sout_valid=0`, `din_ready=1`, no `frame_done`; a following 8'hA5 serializes cleanly as 10100101.
- `din_valid` pulsed mid-frame with 8'hFF → ignored; the stream carries only the original word.
- With `SER_PARITY_EN`: 8'h96 → 9 bits ending in parity 0; 8'h97 → 9 bits ending in 1; `frame_done` in cycle 9.
